pcie_tx_arb: RTL
================

# pcie_tx_arb

Round-robin arbiter that shares the single 16-bit PCIe TLP transmit port between two TLP sources: source 0 is the slave completion engine and source 1 is the master request engine. It owns the core's `tx_req`/`tx_rdy` handshake. It grants one source per TLP and registers the granted source's `st`/`end`/`data` onto the core's transmit pins. It sits between the TLP sequencers and the PCIe core, replacing any hard-wired source-to-`tx_data` connection.

## Interface
- `GNT_TIMEOUT`, default 16: cycles allowed after a grant for the owner's first `st` (only with the timeout feature).
- `pcie_clk` in 1: sole clock, all logic on its rising edge.
- `sys_rst` in 1: reset, synchronous and active-high.
- `src0_req` in 1: source 0 has a complete TLP ready. Held until `src0_gnt`.
- `src0_gnt` out 1: one-cycle pulse; source 0 may start its TLP from the next cycle.
- `src0_st` in 1: first word of the TLP.
- `src0_end` in 1: last word of the TLP.
- `src0_data` in 16: TLP word.
- `src1_req`, `src1_gnt`, `src1_st`, `src1_end`, `src1_data`: same as source 0, for source 1.
- `tx_req` out 1: request to the core.
- `tx_rdy` in 1: core accepts the request.
- `tx_st` out 1: first-word strobe to the core.
- `tx_end` out 1: last-word strobe to the core.
- `tx_data` out 16: TLP word to the core.
- `arb_owner` out 1: current or most recent owner.
- `arb_busy` out 1: high in every state except IDLE.
- `arb_timeout` out 1: one-cycle pulse when a grant is abandoned.

## Operation
- States: IDLE, REQ, XFER.
- **IDLE**
  - If either `req` is high, latch the owner, set `tx_req`=1 and go to REQ.
  - With both requests high, the owner is the source that was not served last (`last`).
  - `last` resets to 1, so source 0 wins the first tie.
- **REQ**
  - Hold `tx_req`=1 until `tx_rdy`=1.
  - On that cycle: `tx_req`<=0, the owner's `gnt`<=1 for one cycle, go to XFER.
  - Request lines are not re-sampled in REQ. A source that drops `req` before its grant still receives the grant.
- **XFER**
  - Every cycle: `tx_data`<=owner `data`, `tx_st`<=owner `st`, `tx_end`<=owner `end`.
  - All inputs from the non-owner are ignored.
  - When the owner's `end` is sampled, update `last`<=owner and go to IDLE.
  - An owner `st` and `end` in the same cycle (single-word TLP) is legal: one transfer, then IDLE.
- Outside XFER, `tx_data`=0, `tx_st`=0 and `tx_end`=0.
- The arbiter never splits, reorders or buffers a TLP. It is a pass-through with a one-cycle register.
- Reset values: `tx_req`=0, `tx_st`=0, `tx_end`=0, `tx_data`=0, `src0_gnt`=0, `src1_gnt`=0, `arb_owner`=0, `arb_busy`=0, `arb_timeout`=0, state IDLE, `last`=1.
- Reset mid-TLP: all outputs take their reset values on the next edge. The partial TLP is dropped and no `tx_end` is generated.

## Timing
- Request to core: `req` sampled high in cycle N gives `tx_req`=1 in N+1.
- Grant: `tx_rdy` sampled high in cycle M gives `gnt`=1 and `tx_req`=0 in M+1.
- Source start: the earliest legal owner `st` is M+2, which appears on `tx_st` in M+3.
- Data latency: exactly one cycle from source pins to core pins, for every word.
- Back-to-back TLPs: owner `end` in cycle K puts the state in IDLE at K+1 and raises the next `tx_req` at K+2 at the earliest. Minimum gap on the core is 2 cycles plus the `tx_rdy` wait.
- Fairness: with both sources requesting continuously, grants alternate 0,1,0,1…

## Configuration
- Macro `PCIE_TX_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on the grant cycle and counts in XFER until the owner's first `st`.
  - If it reaches `GNT_TIMEOUT` with no `st`: go to IDLE, pulse `arb_timeout` for one cycle, set `last`<=owner.
  - Once `st` is seen, the counter stops and there is no further timeout for that TLP.
- **Undefined:**
  - No counter. `arb_timeout` is tied to 0.
  - A granted source that never sends `st` holds the arbiter in XFER until reset.

## Test plan
- Single source: `src0_req`=1, `tx_rdy` one cycle after `tx_req`, 6-word TLP 0x4A00..0x0005 → `src0_gnt` pulse, identical 6 words on `tx_data` one cycle later, `tx_st` on word 0, `tx_end` on word 5, `arb_busy` low after the end.
- Tie after reset: both `req` high together → source 0 granted first, source 1 second. `arb_owner` reads 0 then 1.
- Continuous requests from both sources, 8 TLPs of 3 words each → grants alternate strictly and the non-owner's data (0xDEAD) never appears on `tx_data`.
- Single-word TLP: owner `st`=`end`=1 with data 0x1234 → one core cycle with `tx_st`=`tx_end`=1 and data 0x1234, then IDLE.
- Reset mid-XFER after 2 of 5 words → next edge: all outputs 0, state IDLE; a subsequent tie grants source 0.
- With `PCIE_TX_ARB_TIMEOUT_EN`, `GNT_TIMEOUT`=16: source 1 granted but never sends `st` → `arb_timeout` pulses, arbiter returns to IDLE, and a pending `src0_req` is granted next.

Source files
------------

// File: rtl/pcie_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : pcie_tx_arb
// Description : Two-source round-robin arbiter for the 16-bit PCIe TLP
//               transmit port. Source 0 is the slave completion engine and
//               source 1 is the master request engine. The arbiter grants one
//               source per TLP, owns the core tx_req/tx_rdy handshake, and
//               registers the owner's st/end/data onto the core pins with a
//               fixed one-cycle latency.
//               Optional grant timeout: define PCIE_TX_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_tx_arb #(
  parameter int GNT_TIMEOUT = 16
) (
  input  logic        pcie_clk,
  input  logic        sys_rst,
  // source 0: slave completion engine
  input  logic        src0_req,
  output logic        src0_gnt,
  input  logic        src0_st,
  input  logic        src0_end,
  input  logic [15:0] src0_data,
  // source 1: master request engine
  input  logic        src1_req,
  output logic        src1_gnt,
  input  logic        src1_st,
  input  logic        src1_end,
  input  logic [15:0] src1_data,
  // PCIe core transmit port
  output logic        tx_req,
  input  logic        tx_rdy,
  output logic        tx_st,
  output logic        tx_end,
  output logic [15:0] tx_data,
  // status
  output logic        arb_owner,
  output logic        arb_busy,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_last;        // source served most recently
  logic        w_last_nxt;
  logic        r_owner;       // current or most recent owner
  logic        w_owner_nxt;
  logic        r_tx_req;
  logic        w_tx_req_nxt;
  logic        r_gnt0;
  logic        r_gnt1;
  logic        w_gnt0_nxt;
  logic        w_gnt1_nxt;
  logic        r_busy;
  logic        r_tx_st;
  logic        r_tx_end;
  logic [15:0] r_tx_data;

  logic        w_pick;        // winner of the IDLE-state arbitration
  logic        w_own_st;
  logic        w_own_end;
  logic [15:0] w_own_data;
  logic        w_expire;      // grant abandoned by its owner

  // On a tie the source not served last wins; otherwise the lone requester.
  assign w_pick = (src0_req && src1_req) ? ~r_last : src1_req;

  // Owner-side view of the source pins; the non-owner is never looked at.
  assign w_own_st   = r_owner ? src1_st   : src0_st;
  assign w_own_end  = r_owner ? src1_end  : src0_end;
  assign w_own_data = r_owner ? src1_data : src0_data;

`ifdef PCIE_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(GNT_TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_st_seen;
  logic             r_timeout;

  // Expire when GNT_TIMEOUT XFER cycles have gone by without the owner's st.
  assign w_expire = (r_state == ST_XFER) && !r_st_seen && !w_own_st &&
                    (r_cnt == CNT_W'(GNT_TIMEOUT - 1));

  // Grant watchdog: cleared at grant, counts until the owner's first st.
  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      r_cnt     <= '0;
      r_st_seen <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (r_state == ST_REQ && tx_rdy) begin
        r_cnt     <= '0;
        r_st_seen <= 1'b0;
      end else if (r_state == ST_XFER && !r_st_seen) begin
        if (w_own_st) begin
          r_st_seen <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign arb_timeout = r_timeout;
`else
  // Without the watchdog a grant is held until the owner's end or reset.
  assign w_expire    = 1'b0;
  assign arb_timeout = 1'b0 && (GNT_TIMEOUT > 0);
`endif

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_owner_nxt  = r_owner;
    w_tx_req_nxt = r_tx_req;
    w_gnt0_nxt   = 1'b0;
    w_gnt1_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_req_nxt = 1'b0;
        if (src0_req || src1_req) begin
          w_owner_nxt  = w_pick;
          w_tx_req_nxt = 1'b1;
          w_state_nxt  = ST_REQ;
        end
      end
      ST_REQ: begin
        // Requests are not re-sampled here: the latched owner is granted.
        if (tx_rdy) begin
          w_tx_req_nxt = 1'b0;
          w_gnt0_nxt   = ~r_owner;
          w_gnt1_nxt   = r_owner;
          w_state_nxt  = ST_XFER;
        end
      end
      ST_XFER: begin
        w_tx_req_nxt = 1'b0;
        if (w_own_end) begin
          w_last_nxt  = r_owner;
          w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_last_nxt  = r_owner;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_tx_req_nxt = 1'b0;
        w_state_nxt  = ST_IDLE;
      end
    endcase
  end

  // State, arbitration history and handshake registers.
  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_tx_req <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_owner  <= w_owner_nxt;
      r_tx_req <= w_tx_req_nxt;
      r_gnt0   <= w_gnt0_nxt;
      r_gnt1   <= w_gnt1_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  // One-cycle pass-through of the owner's word; core pins are zero elsewhere.
  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      r_tx_st   <= 1'b0;
      r_tx_end  <= 1'b0;
      r_tx_data <= '0;
    end else if (r_state == ST_XFER) begin
      r_tx_st   <= w_own_st;
      r_tx_end  <= w_own_end;
      r_tx_data <= w_own_data;
    end else begin
      r_tx_st   <= 1'b0;
      r_tx_end  <= 1'b0;
      r_tx_data <= '0;
    end
  end

  assign src0_gnt  = r_gnt0;
  assign src1_gnt  = r_gnt1;
  assign tx_req    = r_tx_req;
  assign tx_st     = r_tx_st;
  assign tx_end    = r_tx_end;
  assign tx_data   = r_tx_data;
  assign arb_owner = r_owner;
  assign arb_busy  = r_busy;

endmodule
`default_nettype wire
